// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream
//   1:4 packet demultiplexer for a valid/ready stream. Each beat is routed
//   through one registered stage to one of four sinks. The destination is
//   taken from in_sel on the first beat of a packet and held until the beat
//   carrying in_last, so a packet never splits across sinks.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_valid/ready  upstream handshake
//   in_data[W]      beat payload
//   in_last         final beat of packet
//   in_sel[2]       destination, sampled on the first beat only
//   out_valid[4]    one-hot per-sink valid
//   out_ready[4]    per-sink ready (only the selected bit matters)
//   out_data[W]     shared payload
//   out_last        shared final-beat flag
//   busy            inside a multi-beat packet
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | next accepted beat starts a packet, routed by in_sel
// LOCKED | mid-packet, beats routed to lock_sel_q until in_last
module demux_1_4_stream #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t       state_q, state_d;
  logic [1:0]   lock_sel_q, lock_sel_d;
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic [1:0]   dest_q, dest_d;

  logic         in_xfer;
  logic         out_xfer;
  logic [1:0]   dest;

  // The held beat may drain in the same cycle a new one is accepted.
  assign out_xfer  = full_q && out_ready[dest_q];
  assign in_ready  = !full_q || out_ready[dest_q];
  assign in_xfer   = in_valid && in_ready;
  assign dest      = (state_q == LOCKED) ? lock_sel_q : in_sel;

  assign out_valid = full_q ? (4'b0001 << dest_q) : 4'b0000;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = (state_q == LOCKED);

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE: begin
        if (in_xfer && !in_last) begin
          state_d    = LOCKED;
          lock_sel_d = in_sel;
        end
      end
      LOCKED: begin
        if (in_xfer && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    last_d = last_q;
    dest_d = dest_q;
    if (in_xfer) begin
      full_d = 1'b1;
      data_d = in_data;
      last_d = in_last;
      dest_d = dest;
    end else if (out_xfer) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= 2'd0;
      full_q     <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      dest_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      full_q     <= full_d;
      data_q     <= data_d;
      last_q     <= last_d;
      dest_q     <= dest_d;
    end
  end

endmodule

// File: tb/tb_demux_1_4_stream.sv
module tb_demux_1_4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  logic [3:0] ro;
  logic       bp_en = 1'b0;
  logic       bp_bit = 1'b1;
  int         bp_idx = 0;
  logic [3:0] bp_pat = 4'b1001;

  int checks = 0;
  int failures = 0;

  assign out_ready = bp_en ? {ro[3:2], bp_bit, ro[0]} : ro;

  demux_1_4_stream #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one held beat plus the open-packet context.
  logic       m_init = 1'b0;
  logic       m_full, m_last, m_pkt;
  logic [7:0] m_data;
  logic [1:0] m_dest, m_psel, m_d;
  logic       m_acc;

  always @(posedge clk) begin
    if (rst) begin
      m_full = 0; m_data = 0; m_last = 0; m_dest = 0; m_pkt = 0; m_psel = 0;
      m_init = 1;
    end else if (m_init) begin
      m_acc = in_valid && (!m_full || out_ready[m_dest]);
      if (m_acc) begin
        m_d    = m_pkt ? m_psel : in_sel;
        m_full = 1; m_data = in_data; m_last = in_last; m_dest = m_d;
        if (in_last) m_pkt = 0;
        else begin m_pkt = 1; m_psel = m_d; end
      end else if (m_full && out_ready[m_dest]) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_out_valid", out_valid, m_full ? (4'b0001 << m_dest) : 4'b0000);
      chk("model_out_data", out_data, m_data);
      chk("model_out_last", out_last, m_last);
      chk("model_busy", busy, m_pkt);
      chk("model_in_ready", in_ready, !m_full || out_ready[m_dest]);
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bp_bit = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end
  end

  // Sink-1 receive monitor for the backpressure run.
  logic mon_en = 1'b0;
  int   rx_idx = 0;
  always @(negedge clk) begin
    if (mon_en && out_valid[1] && out_ready[1]) begin
      chk("bp_rx_data", out_data, 8'h40 + rx_idx[7:0]);
      rx_idx++;
    end
  end

  // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic beat(input logic [1:0] s, input logic [7:0] d, input logic l);
    logic acc;
    in_valid = 1; in_sel = s; in_data = d; in_last = l;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    chk("beat_timeout", 0, 1);
  endtask

  int cnt;

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_last = 0; in_sel = 0; ro = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single-beat routing
    for (int s = 0; s < 4; s++) begin
      beat(s[1:0], 8'hA0 + s[7:0], 1'b1);
      in_valid = 0;
      @(negedge clk);
      chk("single_valid", out_valid, 4'b0001 << s);
      chk("single_data", out_data, 8'hA0 + s);
      chk("single_last", out_last, 1'b1);
      chk("single_busy", busy, 1'b0);
      @(posedge clk); #1;
    end

    // Packet lock: in_sel on later beats ignored
    beat(2'd2, 8'h11, 1'b0);
    in_valid = 0;
    @(negedge clk);
    chk("lock_b1_valid", out_valid, 4'b0100);
    chk("lock_b1_busy", busy, 1'b1);
    @(posedge clk); #1;
    beat(2'd0, 8'h22, 1'b0);
    in_valid = 0;
    @(negedge clk);
    chk("lock_b2_valid", out_valid, 4'b0100);
    chk("lock_b2_data", out_data, 8'h22);
    @(posedge clk); #1;
    beat(2'd3, 8'h33, 1'b1);
    in_valid = 0;
    @(negedge clk);
    chk("lock_b3_valid", out_valid, 4'b0100);
    chk("lock_b3_last", out_last, 1'b1);
    chk("lock_b3_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Backpressure on sink 1
    bp_idx = 0; bp_en = 1; mon_en = 1; rx_idx = 0;
    for (int i = 0; i < 8; i++) beat(2'd1, 8'h40 + i[7:0], i == 7);
    in_valid = 0;
    for (int t = 0; t < 20 && rx_idx < 8; t++) @(posedge clk);
    #1;
    chk("bp_rx_count", rx_idx, 8);
    mon_en = 0; bp_en = 0;
    repeat (2) @(posedge clk); #1;

    // Full throughput to sink 3
    cnt = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        in_valid = 1; in_sel = 2'd3; in_data = 8'h60 + i[7:0]; in_last = (i == 15);
      end else in_valid = 0;
      @(negedge clk);
      if (i > 0 && out_valid == 4'b1000 && out_data == 8'h60 + i[7:0] - 8'd1) cnt++;
      @(posedge clk); #1;
    end
    chk("thru_count", cnt, 16);

    // Back-to-back packets, no idle cycle
    in_valid = 1; in_sel = 2'd0; in_data = 8'h71; in_last = 0;
    @(posedge clk); #1;
    in_sel = 2'd1; in_data = 8'h72; in_last = 1;
    @(negedge clk);
    chk("b2b_1", out_valid, 4'b0001);
    @(posedge clk); #1;
    in_sel = 2'd2; in_data = 8'h73; in_last = 1;
    @(negedge clk);
    chk("b2b_2", out_valid, 4'b0001);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("b2b_3", out_valid, 4'b0100);
    chk("b2b_3_data", out_data, 8'h73);
    @(posedge clk); #1;

    // Reset mid-packet
    beat(2'd1, 8'h81, 1'b0);
    beat(2'd2, 8'h82, 1'b0);
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mrst_valid", out_valid, 4'b0000);
    chk("mrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    beat(2'd3, 8'h90, 1'b1);
    in_valid = 0;
    @(negedge clk);
    chk("mrst_new_valid", out_valid, 4'b1000);
    chk("mrst_new_data", out_data, 8'h90);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- 1:4 packet demultiplexer for a valid/ready stream; the inverse of the 4:1 select mux.
- An upstream source presents data with a 2-bit destination select. The block routes each beat to one of four downstream sinks through a single registered pipeline stage.
- The destination is sampled on the first beat of a packet and held until the beat carrying in_last, so packets are never split across sinks.

Parameters:
W  8  data width in bits

Ports:
clk        input   1    clock, all logic on rising edge
rst        input   1    synchronous reset, active-high
in_valid   input   1    upstream beat valid
in_ready   output  1    block can accept beat this cycle
in_data    input   W    beat payload
in_last    input   1    final beat of packet
in_sel     input   2    destination (0..3); sampled only on first beat of packet
out_valid  output  4    one-hot per-sink valid; bit i means sink i
out_ready  input   4    per-sink ready
out_data   output  W    payload, shared by all sinks
out_last   output  1    final-beat flag, shared by all sinks
busy       output  1    1 while inside a multi-beat packet (state LOCKED)

Behaviour:
- Handshake terms:
  - Input transfer: in_valid && in_ready at the clock edge.
  - Output transfer on sink i: out_valid[i] && out_ready[i].
- Storage is one output register stage: full flag, data_r[W], last_r, dest_r[1:0].
- Combinational outputs:
  - out_valid = full ? (4'b0001 << dest_r) : 4'b0000. Never more than one bit set.
  - out_data = data_r; out_last = last_r.
  - in_ready = !full || out_ready[dest_r]. This gives a full-throughput pass-through of 1 beat/cycle.
  - out_ready bits for non-selected sinks are ignored.
- Latency: a beat accepted at edge k appears on out_* in the cycle after edge k (1-cycle latency).
- Routing FSM, states IDLE and LOCKED, with register lock_sel[1:0]:
  - IDLE: an accepted beat goes to dest = in_sel.
    - If in_last=0, go to LOCKED and set lock_sel = in_sel.
    - If in_last=1 (single-beat packet), stay in IDLE.
  - LOCKED: an accepted beat goes to dest = lock_sel; in_sel is ignored.
    - If in_last=1, go to IDLE.
  - With no input transfer, the state holds.
  - busy = (state == LOCKED).
- Register update each cycle:
  - On input transfer: full=1, data_r=in_data, last_r=in_last, dest_r=dest. This applies even if the old content drains in the same cycle.
  - Else if output transfer: full=0.
  - Else: hold all registers.
- Simultaneous drain and accept: both occur in the same cycle, full stays 1, and no bubble is inserted.
- Backpressure: while full and the selected sink holds out_ready=0, data_r, last_r and dest_r must stay stable and out_valid must stay asserted.
- in_valid may drop between beats of a packet. The state remains LOCKED, and the next beat still goes to lock_sel.
- Reset values (synchronous): full=0, data_r=0, last_r=0, dest_r=0, state=IDLE, lock_sel=0.
  - Resulting outputs: out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1 (from the cycle after reset).
- Reset mid-packet discards the held beat and the packet context. The first beat after reset is treated as a new packet start.
- No error is flagged for a protocol violation (upstream changing in_data while stalled is undefined upstream behaviour).

Test Plan:
- Single-beat routing: after reset, for s = 0..3 send a beat with in_data=8'hA0+s, in_sel=s, in_last=1, all out_ready=1 -> next cycle out_valid = 1<<s, out_data = A0+s, out_last=1; busy stays 0.
- Packet lock: send 3 beats 11,22,33; in_sel=2 on beat 1, then in_sel=0,3 on beats 2 and 3; last on beat 3 -> all three beats appear with out_valid=4'b0100; busy=1 after beat 1 and 0 after beat 3.
- Backpressure: stream 8 beats to sink 1 while out_ready[1] toggles 1,0,0,1,...; out_ready[0,2,3]=1 -> no beat lost or duplicated; out_data stable during stall; in_ready=0 exactly when full && !out_ready[1].
- Full throughput: continuous in_valid, 16 beats to sink 3 with out_ready[3]=1 -> 16 output transfers in 16 consecutive cycles, each delayed 1 cycle from input.
- Back-to-back packets to different sinks: a 2-beat packet to sink 0 immediately followed by a 1-beat packet to sink 2 -> out_valid sequence 0001, 0001, 0100 with no idle cycle.
- Reset mid-packet: assert rst after beat 2 of a 4-beat packet to sink 1 -> next cycle out_valid=0, busy=0; a following beat with in_sel=3 goes to sink 3.
